multicycle_controller: RTL and testbench

//  Moore FSM that sequences the multicycle MIPS datapath. One shared instr/data memory, one ALU.

---
 rtl/mips_mc_pkg.sv | 58 +++++
 rtl/mc_aludec.sv | 27 ++
 rtl/multicycle_controller.sv | 162 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding, opcode/funct
// values, ALU control codes and datapath mux select codes.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_byte_op(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: the FSM picks add/sub directly or defers to the R-type funct field.
module mc_aludec
    import mips_mc_pkg::*;
(
    input  logic [5:0] funct_i,
    input  logic [1:0] aluop_i,
    output logic [2:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_SUB:  alucontrol_o = ALU_SUB;
                    FN_AND:  alucontrol_o = ALU_AND;
                    FN_OR:   alucontrol_o = ALU_OR;
                    FN_SLT:  alucontrol_o = ALU_SLT;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer for the multicycle MIPS datapath; outputs decode from the current state,
// gated by mem_ready where an access may stall and by zero for the branch PC update.
module multicycle_controller
    import mips_mc_pkg::*;
#(
    parameter bit STALL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       byte_enable,
    output logic       iord,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic [3:0] state_o
);

    state_t     state_q, state_d;
    logic       mem_rdy;
    logic       pcwrite, branch, mem_state;
    logic       irwrite_d, memwrite_d, regwrite_d, done_d;
    logic [1:0] aluop;

    assign mem_rdy = STALL_EN ? mem_ready : 1'b1;

    always_comb begin
        state_d    = state_q;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite_d  = 1'b0;
        memwrite_d = 1'b0;
        regwrite_d = 1'b0;
        done_d     = 1'b0;
        mem_state  = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RT;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                alusrcb   = SRCB_FOUR;
                irwrite_d = mem_rdy;
                pcwrite   = mem_rdy;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                case (op)
                    OP_LW, OP_LB, OP_SW, OP_SB: state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_EXEC;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_ADDI:  state_d = S_ADDIEX;
                    OP_J:     state_d = S_JUMP;
                    default: begin
                        // Unrecognised opcodes retire here as a NOP.
                        state_d = S_FETCH;
                        done_d  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca   = 1'b1;
                alusrcb   = SRCB_IMM;
                mem_state = 1'b1;
                state_d   = ((op == OP_LW) || (op == OP_LB)) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord      = 1'b1;
                mem_state = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_d = 1'b1;
                done_d     = 1'b1;
                mem_state  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_d = 1'b1;
                mem_state  = 1'b1;
                if (mem_rdy) begin
                    done_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_d = 1'b1;
                done_d     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
                done_d  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_d = 1'b1;
                done_d     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
                done_d  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks every enable combinationally so a held reset never leaks a write.
    assign pcen        = reset & (pcwrite | (branch & zero));
    assign irwrite     = reset & irwrite_d;
    assign memwrite    = reset & memwrite_d;
    assign regwrite    = reset & regwrite_d;
    assign instr_done  = reset & done_d;
    assign byte_enable = reset & mem_state & is_byte_op(op);
    assign state_o     = state_q;

    mc_aludec u_aludec (
        .funct_i      (funct),
        .aluop_i      (aluop),
        .alucontrol_o (alucontrol)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instructions against a per-state
// expectation table and a latency rule, plus reset behaviour.
module tb_multicycle_controller;
    import mips_mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       pcen, irwrite, memwrite, byte_enable, iord, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done;
    logic [3:0] state_o;
    logic [16:0] dut_v;

    int checks   = 0;
    int failures = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .byte_enable(byte_enable),
        .iord(iord), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .instr_done(instr_done), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign dut_v = {pcen, irwrite, memwrite, byte_enable, iord, regwrite, regdst, memtoreg,
                    alusrca, alusrcb, pcsrc, alucontrol, instr_done};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs for one cycle; m marks the fields the state actually defines.
    function automatic void model(input state_t s, input logic [5:0] o, input logic [5:0] f,
                                  input logic mr, input logic z, input logic rst,
                                  output logic [16:0] v, output logic [16:0] m);
        logic pc, ir, mw, be, io, rw, rd, mt, sa, dn, bytes, known;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        logic k_io, k_rd, k_mt, k_sa, k_sb, k_ps, k_ac;
        pc = 0; ir = 0; mw = 0; be = 0; io = 0; rw = 0; rd = 0; mt = 0; sa = 0; dn = 0;
        sb = 2'b00; ps = 2'b00; ac = 3'b010;
        k_io = 0; k_rd = 0; k_mt = 0; k_sa = 0; k_sb = 0; k_ps = 0; k_ac = 0;
        bytes = (o == 6'b100000) || (o == 6'b101000);
        known = (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) || (o == 6'b100000) ||
                (o == 6'b101000) || (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
        case (s)
            S_FETCH: begin
                io = 0; k_io = 1; sa = 0; k_sa = 1; sb = 2'b01; k_sb = 1;
                ac = 3'b010; k_ac = 1; ps = 2'b00; k_ps = 1; ir = mr; pc = mr;
            end
            S_DECODE: begin sa = 0; k_sa = 1; sb = 2'b11; k_sb = 1; k_ac = 1; dn = !known; end
            S_MEMADR: begin sa = 1; k_sa = 1; sb = 2'b10; k_sb = 1; k_ac = 1; be = bytes; end
            S_MEMRD:  begin io = 1; k_io = 1; be = bytes; end
            S_MEMWB:  begin rd = 0; k_rd = 1; mt = 1; k_mt = 1; rw = 1; dn = 1; be = bytes; end
            S_MEMWR:  begin io = 1; k_io = 1; mw = 1; dn = mr; be = bytes; end
            S_EXEC:   begin sa = 1; k_sa = 1; sb = 2'b00; k_sb = 1; ac = alu_of(f); k_ac = 1; end
            S_ALUWB:  begin rd = 1; k_rd = 1; mt = 0; k_mt = 1; rw = 1; dn = 1; end
            S_BRANCH: begin
                sa = 1; k_sa = 1; sb = 2'b00; k_sb = 1; ac = 3'b110; k_ac = 1;
                ps = 2'b01; k_ps = 1; pc = z; dn = 1;
            end
            S_ADDIEX: begin sa = 1; k_sa = 1; sb = 2'b10; k_sb = 1; k_ac = 1; end
            S_ADDIWB: begin rd = 0; k_rd = 1; mt = 0; k_mt = 1; rw = 1; dn = 1; end
            S_JUMP:   begin ps = 2'b10; k_ps = 1; pc = 1; dn = 1; end
            default: ;
        endcase
        if (rst) begin pc = 0; ir = 0; mw = 0; rw = 0; dn = 0; be = 0; end
        v = {pc, ir, mw, be, io, rw, rd, mt, sa, sb, ps, ac, dn};
        m = {4'b1111, k_io, 1'b1, k_rd, k_mt, k_sa, {2{k_sb}}, {2{k_ps}}, {3{k_ac}}, 1'b1};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // zmode: 0/1 force zero, 2 random. fst/mst: wait cycles in fetch and in the data access.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fst,
                             input int mst, input int zmode);
        state_t      ps[$];
        logic        pm[$];
        int          lat;
        int          done_at;
        logic [16:0] v, m;
        done_at = -1;
        for (int i = 0; i < fst; i++) begin ps.push_back(S_FETCH); pm.push_back(1'b0); end
        ps.push_back(S_FETCH);  pm.push_back(1'b1);
        ps.push_back(S_DECODE); pm.push_back(rb());
        case (o)
            6'b000000: begin lat = 4; ps.push_back(S_EXEC); pm.push_back(rb());
                             ps.push_back(S_ALUWB); pm.push_back(rb()); end
            6'b001000: begin lat = 4; ps.push_back(S_ADDIEX); pm.push_back(rb());
                             ps.push_back(S_ADDIWB); pm.push_back(rb()); end
            6'b000100: begin lat = 3; ps.push_back(S_BRANCH); pm.push_back(rb()); end
            6'b000010: begin lat = 3; ps.push_back(S_JUMP); pm.push_back(rb()); end
            6'b100011, 6'b100000: begin
                lat = 5 + mst;
                ps.push_back(S_MEMADR); pm.push_back(rb());
                for (int i = 0; i < mst; i++) begin ps.push_back(S_MEMRD); pm.push_back(1'b0); end
                ps.push_back(S_MEMRD); pm.push_back(1'b1);
                ps.push_back(S_MEMWB); pm.push_back(rb());
            end
            6'b101011, 6'b101000: begin
                lat = 4 + mst;
                ps.push_back(S_MEMADR); pm.push_back(rb());
                for (int i = 0; i < mst; i++) begin ps.push_back(S_MEMWR); pm.push_back(1'b0); end
                ps.push_back(S_MEMWR); pm.push_back(1'b1);
            end
            default: lat = 2;
        endcase
        lat += fst;
        for (int i = 0; i < ps.size(); i++) begin
            @(negedge clk);
            op = o; funct = f; mem_ready = pm[i];
            zero = (zmode == 2) ? rb() : zmode[0];
            #1;
            check($sformatf("state_op%b_c%0d", o, i), state_o, ps[i]);
            model(ps[i], o, f, mem_ready, zero, 1'b0, v, m);
            check($sformatf("outs_%s_op%b", ps[i].name(), o), dut_v & m, v & m);
            if (instr_done && done_at < 0) done_at = i;
        end
        check($sformatf("latency_op%b", o), done_at + 1, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [5:0]  ops [10];
        logic [5:0]  fns [6];
        logic [16:0] v, m;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b100000, 6'b101000,
                6'b000100, 6'b001000, 6'b000010, 6'b111111, 6'b010101};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

        reset = 1'b0; op = 6'b000000; funct = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
        #1;
        check("reset_state", state_o, S_FETCH);
        model(S_FETCH, op, funct, mem_ready, zero, 1'b1, v, m);
        check("reset_outs", dut_v, v);
        repeat (2) @(negedge clk);
        mem_ready = 1'b0; reset = 1'b1;
        #1;
        check("post_reset_state", state_o, S_FETCH);

        run_instr(6'b000000, 6'b100000, 0, 0, 2);   // add
        run_instr(6'b100011, 6'b000000, 0, 2, 2);   // lw, 2 wait cycles
        run_instr(6'b000100, 6'b000000, 0, 0, 1);   // beq taken
        run_instr(6'b000100, 6'b000000, 0, 0, 0);   // beq not taken
        run_instr(6'b101000, 6'b000000, 0, 3, 2);   // sb, 3 wait cycles
        run_instr(6'b111111, 6'b000000, 0, 0, 2);   // unknown op
        run_instr(6'b000000, 6'b101010, 2, 0, 2);   // slt after fetch stall

        for (int n = 0; n < 60; n++) begin
            logic [5:0] f;
            f = fns[$urandom_range(0, 5)];
            if (f == 6'b000000) f = 6'($urandom_range(0, 63));
            run_instr(ops[$urandom_range(0, 9)], f, $urandom_range(0, 2), $urandom_range(0, 3), 2);
        end

        // Reset asserted while a store is waiting on memory.
        @(negedge clk); op = 6'b101011; mem_ready = 1'b1; #1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0; #1;
        check("memwr_state", state_o, S_MEMWR);
        check("memwr_before", memwrite, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("memwr_async_drop", memwrite, 1'b0);
        check("memwr_async_state", state_o, S_FETCH);
        model(S_FETCH, op, funct, mem_ready, zero, 1'b1, v, m);
        check("memwr_reset_outs", dut_v, v);
        @(negedge clk); reset = 1'b1; mem_ready = 1'b0; #1;
        check("release_state", state_o, S_FETCH);
        model(S_FETCH, op, funct, mem_ready, zero, 1'b0, v, m);
        check("release_outs", dut_v & m, v & m);
        run_instr(6'b000000, 6'b100010, 0, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
